// File: rtl/key_event_sched.sv
// rtl/key_event_sched.sv - round-robin key press serialiser feeding a small show-ahead FIFO
module key_event_sched #(
   parameter int KEY_W  = 6,
   parameter int CODE_W = 3,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [KEY_W-1:0]  press,
   input  logic              en,
   input  logic              flush,
   output logic              ev_valid,
   output logic [CODE_W-1:0] ev_code,
   input  logic              ev_ready,
   output logic [ADDR_W:0]   fifo_cnt,
   output logic [7:0]        drop_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [CODE_W-1:0] LAST_KEY = CODE_W'(KEY_W - 1);

   logic [KEY_W-1:0]  pend;
   logic [KEY_W-1:0]  sel;
   logic [KEY_W-1:0]  gnt;
   logic [CODE_W-1:0] rr_ptr;
   logic [CODE_W-1:0] winner;
   logic [CODE_W-1:0] rr_next;
   logic [CODE_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic [7:0]        drops;
   logic              found;
   logic              do_gnt;
   logic              do_pop;
   logic              drop_hit;
   int                idx;

   // First set pending bit at or above rr_ptr, wrapping past the top key.
   always_comb begin
      sel    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < KEY_W; k++) begin
         idx = (int'(rr_ptr) + k) % KEY_W;
         if (!found && pend[idx]) begin
            found    = 1'b1;
            winner   = CODE_W'(idx);
            sel[idx] = 1'b1;
         end
      end
   end

   // Space is judged on the registered count, so a same-cycle pop never helps.
   assign do_gnt   = found && (cnt != FULL_CNT);
   assign gnt      = do_gnt ? sel : '0;
   assign do_pop   = ev_valid && ev_ready;
   assign rr_next  = (winner == LAST_KEY) ? '0 : winner + 1'b1;
   assign drop_hit = en && |(press & pend & ~gnt);

   assign ev_valid = (cnt != '0);
   assign ev_code  = mem[rd_ptr];
   assign fifo_cnt = cnt;
   assign drop_cnt = drops;

   always_ff @(posedge clk) begin
      if (do_gnt && !flush && !rst)
         mem[wr_ptr] <= winner;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend   <= '0;
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         drops  <= '0;
      end else if (flush) begin
         pend   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         pend <= en ? ((pend & ~gnt) | press) : '0;
         if (do_gnt) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr_ptr <= rr_next;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_gnt, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (drop_hit && drops != 8'hFF)
            drops <= drops + 1'b1;
      end
   end

endmodule

// File: tb/tb_key_event_sched.sv
// tb/tb_key_event_sched.sv - directed vector bench for key_event_sched
module tb_key_event_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] press = '0;
   logic       en = 1'b1;
   logic       flush = 1'b0;
   logic       ev_valid;
   logic [2:0] ev_code;
   logic       ev_ready = 1'b0;
   logic [2:0] fifo_cnt;
   logic [7:0] drop_cnt;

   int total = 0;
   int bad = 0;

   key_event_sched #(.KEY_W(6), .CODE_W(3), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .press(press), .en(en), .flush(flush),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
      .fifo_cnt(fifo_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       ready;
      logic [5:0] press;
      logic       valid;
      logic [2:0] code;
      logic [2:0] cnt;
      logic [7:0] drop;
      logic [5:0] pend;
   } vec_t;

   vec_t vecs [28];

   function automatic vec_t mk(input logic r, input logic rdy, input logic [5:0] p,
                               input logic v, input logic [2:0] c, input logic [2:0] n,
                               input logic [7:0] d, input logic [5:0] pd);
      vec_t t;
      t.rst = r; t.ready = rdy; t.press = p; t.valid = v;
      t.code = c; t.cnt = n; t.drop = d; t.pend = pd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic f, input logic rdy,
                       input logic [5:0] p);
      rst = r; en = e; flush = f; ev_ready = rdy; press = p;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [2:0] n,
                            input logic [7:0] d, input logic [5:0] pd);
      chk({tag, ".valid"}, 32'(ev_valid), 32'(v));
      chk({tag, ".cnt"}, 32'(fifo_cnt), 32'(n));
      chk({tag, ".drop"}, 32'(drop_cnt), 32'(d));
      chk({tag, ".pend"}, 32'(dut.pend), 32'(pd));
   endtask

   initial begin
      vecs[0]  = mk(0, 1, 6'b000100, 0, 0, 0, 0, 6'b000100);
      vecs[1]  = mk(0, 1, 6'b000000, 1, 2, 1, 0, 6'b000000);
      vecs[2]  = mk(0, 1, 6'b000000, 0, 0, 0, 0, 6'b000000);
      vecs[3]  = mk(1, 1, 6'b000000, 0, 0, 0, 0, 6'b000000);
      vecs[4]  = mk(0, 1, 6'b101001, 0, 0, 0, 0, 6'b101001);
      vecs[5]  = mk(0, 1, 6'b000000, 1, 0, 1, 0, 6'b101000);
      vecs[6]  = mk(0, 1, 6'b000000, 1, 3, 1, 0, 6'b100000);
      vecs[7]  = mk(0, 1, 6'b000000, 1, 5, 1, 0, 6'b000000);
      vecs[8]  = mk(0, 1, 6'b000000, 0, 0, 0, 0, 6'b000000);
      vecs[9]  = mk(0, 0, 6'b000001, 0, 0, 0, 0, 6'b000001);
      vecs[10] = mk(0, 0, 6'b000010, 1, 0, 1, 0, 6'b000010);
      vecs[11] = mk(0, 0, 6'b000100, 1, 0, 2, 0, 6'b000100);
      vecs[12] = mk(0, 0, 6'b001000, 1, 0, 3, 0, 6'b001000);
      vecs[13] = mk(0, 0, 6'b010000, 1, 0, 4, 0, 6'b010000);
      vecs[14] = mk(0, 0, 6'b000000, 1, 0, 4, 0, 6'b010000);
      vecs[15] = mk(0, 1, 6'b000000, 1, 1, 3, 0, 6'b010000);
      vecs[16] = mk(0, 1, 6'b000000, 1, 2, 3, 0, 6'b000000);
      vecs[17] = mk(0, 1, 6'b000000, 1, 3, 2, 0, 6'b000000);
      vecs[18] = mk(0, 1, 6'b000000, 1, 4, 1, 0, 6'b000000);
      vecs[19] = mk(0, 1, 6'b000000, 0, 0, 0, 0, 6'b000000);
      vecs[20] = mk(0, 0, 6'b001101, 0, 0, 0, 0, 6'b001101);
      vecs[21] = mk(0, 0, 6'b000000, 1, 0, 1, 0, 6'b001100);
      vecs[22] = mk(0, 0, 6'b000000, 1, 0, 2, 0, 6'b001000);
      vecs[23] = mk(0, 0, 6'b000000, 1, 0, 3, 0, 6'b000000);
      vecs[24] = mk(0, 0, 6'b010010, 1, 0, 3, 0, 6'b010010);
      vecs[25] = mk(0, 0, 6'b000000, 1, 0, 4, 0, 6'b000010);
      vecs[26] = mk(0, 0, 6'b000010, 1, 0, 4, 1, 6'b000010);
      vecs[27] = mk(0, 0, 6'b000010, 1, 0, 4, 2, 6'b000010);

      step(1, 1, 0, 0, 6'b0);
      step(1, 1, 0, 0, 6'b0);
      chk_state("reset", 0, 0, 0, 6'b0);
      chk("reset.rr", 32'(dut.rr_ptr), 32'd0);

      for (int i = 0; i < 28; i++) begin
         step(vecs[i].rst, 1'b1, 1'b0, vecs[i].ready, vecs[i].press);
         chk_state($sformatf("vec%0d", i), vecs[i].valid, vecs[i].cnt, vecs[i].drop, vecs[i].pend);
         if (vecs[i].valid)
            chk($sformatf("vec%0d.code", i), 32'(ev_code), 32'(vecs[i].code));
      end

      // full queue, key 1 pending: every colliding pulse is one drop, saturating at 255
      for (int i = 0; i < 252; i++) step(0, 1, 0, 0, 6'b000010);
      chk("sat.drop254", 32'(drop_cnt), 32'd254);
      step(0, 1, 0, 0, 6'b000010);
      chk("sat.drop255", 32'(drop_cnt), 32'd255);
      for (int i = 0; i < 47; i++) step(0, 1, 0, 0, 6'b000010);
      chk_state("sat.end", 1, 4, 8'd255, 6'b000010);

      step(0, 1, 1, 1, 6'b000010);
      chk_state("flush1", 0, 0, 8'd255, 6'b0);
      chk("flush1.rr", 32'(dut.rr_ptr), 32'd5);

      step(0, 1, 0, 0, 6'b001011);
      step(0, 1, 0, 0, 6'b000000);
      chk("pre_flush.code", 32'(ev_code), 32'd0);
      step(0, 1, 0, 0, 6'b000000);
      chk_state("pre_flush", 1, 2, 8'd255, 6'b001000);
      step(0, 1, 1, 1, 6'b000001);
      chk_state("flush2", 0, 0, 8'd255, 6'b0);
      chk("flush2.rr", 32'(dut.rr_ptr), 32'd2);
      step(0, 1, 0, 0, 6'b000000);
      chk_state("post_flush", 0, 0, 8'd255, 6'b0);

      step(0, 1, 0, 0, 6'b000001);
      step(0, 1, 0, 0, 6'b000000);
      chk("pre_rst.cnt", 32'(fifo_cnt), 32'd1);
      step(1, 1, 1, 1, 6'b000001);
      chk_state("rst_mid", 0, 0, 0, 6'b0);
      chk("rst_mid.rr", 32'(dut.rr_ptr), 32'd0);

      step(0, 0, 0, 0, 6'b111111);
      chk_state("en_off1", 0, 0, 0, 6'b0);
      step(0, 0, 0, 0, 6'b111111);
      chk_state("en_off2", 0, 0, 0, 6'b0);

      step(0, 1, 0, 0, 6'b000011);
      step(0, 1, 0, 0, 6'b000000);
      step(0, 1, 0, 0, 6'b000000);
      chk_state("pp.setup", 1, 2, 0, 6'b0);
      step(0, 1, 0, 0, 6'b000100);
      chk_state("pp.pend", 1, 2, 0, 6'b000100);
      step(0, 1, 0, 1, 6'b000000);
      chk_state("pp.both", 1, 2, 0, 6'b0);
      chk("pp.both.code", 32'(ev_code), 32'd1);
      step(0, 1, 0, 1, 6'b000000);
      chk("pp.after.cnt", 32'(fifo_cnt), 32'd1);
      chk("pp.after.code", 32'(ev_code), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
